dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter that shares the pipelined CPU's single data memory between the MEM stage and a debug/loader port. It sequences each access over a fixed memory latency and stalls the CPU while its access is pending. Debug requests cannot starve: after a bounded number of consecutive CPU wins, debug is forced through. The block sits between `Pipe_CPU`'s MEM stage, the `DM` array and the bench or loader master.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 2: memory cycles per access, ≥1.
- `STARVE_MAX`, 4: consecutive CPU grants allowed while debug waits, ≥1.

- `clk_i` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-high reset (1 = reset).
- `cpu_req_i` in 1: CPU access request, level, held until `cpu_done_o`.
- `cpu_we_i` in 1: 1 = write.
- `cpu_addr_i` in ADDR_W: byte address.
- `cpu_wdata_i` in DATA_W: write data.
- `cpu_rdata_o` out DATA_W: read data, valid while `cpu_done_o`=1.
- `cpu_done_o` out 1: one-cycle completion pulse.
- `cpu_stall_o` out 1: `cpu_req_i & ~cpu_done_o`, combinational.
- `dbg_req_i`, `dbg_we_i`, `dbg_addr_i`, `dbg_wdata_i` in: same meaning for the debug port.
- `dbg_rdata_o`, `dbg_done_o` out: same meaning for the debug port.
- `mem_en_o` out 1: memory access active.
- `mem_we_o` out 1: memory write strobe.
- `mem_addr_o` out ADDR_W: latched address.
- `mem_wdata_o` out DATA_W: latched write data.
- `mem_rdata_i` in DATA_W: memory read data, sampled on the last BUSY cycle.

## Operation
- FSM states:
  - IDLE: decides the grant.
  - BUSY: access in flight.
  - RESP: done pulse is driven.
- IDLE with no request: stay in IDLE.
- IDLE with one request: grant that requester.
- IDLE with both requesting:
  - Grant CPU if `starve_cnt` < STARVE_MAX.
  - Otherwise grant debug.
- On grant:
  - Latch owner, we, addr and wdata.
  - Set `lat_cnt`=0.
  - Go to BUSY.
- `starve_cnt`:
  - Increments on each CPU grant made while `dbg_req_i`=1; saturates at STARVE_MAX.
  - Clears on any debug grant.
- BUSY:
  - `mem_en_o`=1 and `lat_cnt` increments each cycle.
  - When `lat_cnt`==MEM_LAT-1, capture `mem_rdata_i` into the owner's rdata register and go to RESP.
- `mem_we_o`=1 only on the final BUSY cycle and only if the latched we=1. This gives exactly one write per access.
- RESP:
  - Owner's done output is 1; the other done output stays 0.
  - Go to IDLE.
  - Requests are not re-arbitrated in RESP, because the completing requester may still hold req this cycle.
- Request or data changes after grant are ignored until the next IDLE.
- rdata registers hold their value between accesses. Reads and writes both update rdata; for writes the captured value is don't-care.

## Timing
- Reset values: state=IDLE, `lat_cnt`=0, `starve_cnt`=0.
- All outputs are 0 in reset, including both rdata outputs.
- Reset asserted mid-BUSY:
  - Immediate return to IDLE.
  - `mem_en_o` and `mem_we_o` drop asynchronously.
  - No done pulse is generated.
  - A write not yet on its final cycle is aborted.
- Latency: request sampled in IDLE at edge t.
  - BUSY covers cycles t+1 .. t+MEM_LAT.
  - done=1 in cycle t+MEM_LAT+1.
  - The next grant is possible at edge t+MEM_LAT+2.
  - Minimum occupancy per access is MEM_LAT+2 cycles.
- `cpu_stall_o` is 1 from the cycle `cpu_req_i` rises through the cycle before `cpu_done_o`.
- MEM_LAT=1: BUSY lasts one cycle and `mem_we_o` coincides with the only BUSY cycle.

## Test plan
- CPU read, MEM_LAT=2, memory returns 0x0000_00AB at addr 0x10:
  - `cpu_req_i` rises at cycle 0.
  - BUSY in cycles 1–2.
  - `cpu_done_o`=1 and `cpu_rdata_o`=0xAB in cycle 3.
  - `cpu_stall_o`=1 in cycles 0–2.
- Debug write of 0x55 to addr 0x20:
  - Exactly one `mem_we_o` pulse, in cycle 2, with `mem_addr_o`=0x20 and `mem_wdata_o`=0x55.
  - `dbg_done_o` in cycle 3.
- Both ports request continuously, STARVE_MAX=4: grant order is CPU, CPU, CPU, CPU, DBG, then repeats. `starve_cnt` returns to 0 after the debug grant.
- Requests sampled at the IDLE edge after completion: a requester that holds req through its own RESP cycle is granted once, never twice. Both ports present in that IDLE are arbitrated normally.
- Reset pulse during BUSY cycle 1 of a CPU write:
  - `mem_en_o` and `mem_we_o` fall immediately.
  - No `mem_we_o` pulse and no done pulse.
  - Memory location unchanged.
  - After reset release, a new read completes normally.
- MEM_LAT=1 parameter sweep: done arrives 2 cycles after the request is sampled, and a single write strobe is produced.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundle of the CPU port, the debug/loader port and the
// data-memory port around dm_arbiter.
//   slave  - arbiter side: takes both requests and drives the memory.
//   master - environment side: CPU MEM stage, debug master and DM array.
// Port summary:
//   cpu_* / dbg_* : req, we, addr, wdata in; rdata, done out (plus cpu stall)
//   mem_*         : en, we, addr, wdata out; rdata in
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              cpu_done_o;
  logic              cpu_stall_o;

  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic              dbg_done_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_done_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_rdata_o, dbg_done_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_done_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_rdata_o, dbg_done_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data memory between the CPU MEM stage and a
// debug/loader port. Each access takes MEM_LAT BUSY cycles followed by one
// RESP cycle carrying the owner's done pulse. CPU wins ties unless it has
// already won STARVE_MAX grants in a row while debug was waiting.
// Ports:
//   clk_i - clock, rising edge
//   rst_n - asynchronous reset, active HIGH despite the name
//   bus   - dm_arbiter_if.slave (CPU port, debug port, memory port)
module dm_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk_i,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAST   = LW'(MEM_LAT - 1);
  // The write strobe is registered, so it is raised one BUSY cycle early.
  localparam logic [LW-1:0] PRE_WE = LW'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam logic [SW-1:0] SMAX   = SW'(STARVE_MAX);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  typedef struct packed {
    logic              dbg;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t        state;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  req_t          cur;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
  logic          cpu_done, dbg_done, mem_en, mem_we;

  logic grant_cpu, grant_dbg;
  req_t cpu_pkt, dbg_pkt;

  assign grant_cpu = bus.cpu_req_i & (~bus.dbg_req_i | (starve_cnt < SMAX));
  assign grant_dbg = bus.dbg_req_i & ~grant_cpu;
  assign cpu_pkt   = '{dbg: 1'b0, we: bus.cpu_we_i, addr: bus.cpu_addr_i, wdata: bus.cpu_wdata_i};
  assign dbg_pkt   = '{dbg: 1'b1, we: bus.dbg_we_i, addr: bus.dbg_addr_i, wdata: bus.dbg_wdata_i};

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      cur        <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_done   <= 1'b0;
      dbg_done   <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_cpu || grant_dbg) begin
            cur     <= grant_dbg ? dbg_pkt : cpu_pkt;
            lat_cnt <= '0;
            mem_en  <= 1'b1;
            // With a single BUSY cycle the strobe belongs on that first cycle.
            mem_we  <= (MEM_LAT == 1) && (grant_dbg ? bus.dbg_we_i : bus.cpu_we_i);
            if (grant_dbg)
              starve_cnt <= '0;
            else if (bus.dbg_req_i && (starve_cnt < SMAX))
              starve_cnt <= starve_cnt + 1'b1;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_cnt == LAST) begin
            if (cur.dbg) dbg_rdata <= bus.mem_rdata_i;
            else         cpu_rdata <= bus.mem_rdata_i;
            cpu_done <= ~cur.dbg;
            dbg_done <= cur.dbg;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            state    <= S_RESP;
          end else begin
            mem_we <= cur.we && (lat_cnt == PRE_WE);
          end
        end
        // Completing requester may still hold req here, so no arbitration.
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata_o = cpu_rdata;
  assign bus.cpu_done_o  = cpu_done;
  assign bus.cpu_stall_o = bus.cpu_req_i & ~cpu_done;
  assign bus.dbg_rdata_o = dbg_rdata;
  assign bus.dbg_done_o  = dbg_done;
  assign bus.mem_en_o    = mem_en;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_addr_o  = cur.addr;
  assign bus.mem_wdata_o = cur.wdata;
endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a ();
  dm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b ();

  dm_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clk_i(clk), .rst_n(rst), .bus(a.slave));
  dm_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk_i(clk), .rst_n(rst), .bus(b.slave));

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int we1_cnt = 0;

  // Data memory model behind u_dut; the MEM_LAT=1 instance sees a fixed pattern.
  logic [31:0] mem [0:63];
  assign a.mem_rdata_i = mem[a.mem_addr_o[7:2]];
  assign b.mem_rdata_i = 32'h1234_0000 | b.mem_addr_o;

  always @(posedge clk) begin
    if (a.mem_we_o) begin
      mem[a.mem_addr_o[7:2]] = a.mem_wdata_o;
      we_cnt = we_cnt + 1;
    end
    if (b.mem_we_o) we1_cnt = we1_cnt + 1;
  end

  typedef struct { bit dbg; bit rd; logic [31:0] data; } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (a.cpu_done_o || a.dbg_done_o) begin
      if (sb0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb0 unexpected done: cpu=%0d dbg=%0d", a.cpu_done_o, a.dbg_done_o);
      end else begin
        e0 = sb0.pop_front();
        chk("sb0 owner {cpu,dbg}", {30'd0, a.cpu_done_o, a.dbg_done_o}, {30'd0, !e0.dbg, e0.dbg});
        if (e0.rd) chk("sb0 rdata", e0.dbg ? a.dbg_rdata_o : a.cpu_rdata_o, e0.data);
      end
    end
  end

  always @(negedge clk) begin
    if (b.cpu_done_o || b.dbg_done_o) begin
      if (sb1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1 unexpected done: cpu=%0d dbg=%0d", b.cpu_done_o, b.dbg_done_o);
      end else begin
        e1 = sb1.pop_front();
        chk("sb1 owner {cpu,dbg}", {30'd0, b.cpu_done_o, b.dbg_done_o}, {30'd0, !e1.dbg, e1.dbg});
        if (e1.rd) chk("sb1 rdata", e1.dbg ? b.dbg_rdata_o : b.cpu_rdata_o, e1.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
    mem[4] = 32'h0000_00AB;  // addr 0x10
    a.cpu_req_i = 0; a.cpu_we_i = 0; a.cpu_addr_i = 0; a.cpu_wdata_i = 0;
    a.dbg_req_i = 0; a.dbg_we_i = 0; a.dbg_addr_i = 0; a.dbg_wdata_i = 0;
    b.cpu_req_i = 0; b.cpu_we_i = 0; b.cpu_addr_i = 0; b.cpu_wdata_i = 0;
    b.dbg_req_i = 0; b.dbg_we_i = 0; b.dbg_addr_i = 0; b.dbg_wdata_i = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst cpu_done", a.cpu_done_o, 0);
    chk("rst dbg_done", a.dbg_done_o, 0);
    chk("rst mem_en", a.mem_en_o, 0);
    chk("rst mem_we", a.mem_we_o, 0);
    chk("rst mem_addr", a.mem_addr_o, 0);
    chk("rst mem_wdata", a.mem_wdata_o, 0);
    chk("rst cpu_rdata", a.cpu_rdata_o, 0);
    chk("rst dbg_rdata", a.dbg_rdata_o, 0);
    chk("rst stall", a.cpu_stall_o, 0);
    rst = 0;
    tick();

    // T1: CPU read of 0x10 -> 0xAB, done in cycle 3
    a.cpu_req_i = 1; a.cpu_we_i = 0; a.cpu_addr_i = 32'h10;
    sb0.push_back('{1'b0, 1'b1, 32'h0000_00AB});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t1 stall c%0d", k), a.cpu_stall_o, (k < 3));
      chk($sformatf("t1 cpu_done c%0d", k), a.cpu_done_o, (k == 3));
      chk($sformatf("t1 mem_en c%0d", k), a.mem_en_o, (k == 1 || k == 2));
      chk($sformatf("t1 mem_we c%0d", k), a.mem_we_o, 0);
      tick();
      if (k == 3) a.cpu_req_i = 0;
    end

    // T2: debug write 0x55 to 0x20, one strobe in cycle 2
    we_cnt = 0;
    a.dbg_req_i = 1; a.dbg_we_i = 1; a.dbg_addr_i = 32'h20; a.dbg_wdata_i = 32'h55;
    sb0.push_back('{1'b1, 1'b0, 32'h0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t2 mem_we c%0d", k), a.mem_we_o, (k == 2));
      if (k == 2) begin
        chk("t2 mem_addr", a.mem_addr_o, 32'h20);
        chk("t2 mem_wdata", a.mem_wdata_o, 32'h55);
      end
      chk($sformatf("t2 dbg_done c%0d", k), a.dbg_done_o, (k == 3));
      chk($sformatf("t2 cpu_done c%0d", k), a.cpu_done_o, 0);
      tick();
      if (k == 3) a.dbg_req_i = 0;
    end
    chk("t2 write count", we_cnt, 1);
    chk("t2 mem[0x20]", mem[8], 32'h55);

    // T3: both request continuously: C,C,C,C,D repeating
    a.cpu_req_i = 1; a.cpu_we_i = 0; a.cpu_addr_i = 32'h10;
    a.dbg_req_i = 1; a.dbg_we_i = 0; a.dbg_addr_i = 32'h04;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) sb0.push_back('{1'b0, 1'b1, 32'h0000_00AB});
      sb0.push_back('{1'b1, 1'b1, 32'hA000_0001});
    end
    n = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge clk);
      if (a.cpu_done_o || a.dbg_done_o) n++;
      tick();
    end
    a.cpu_req_i = 0; a.dbg_req_i = 0;
    chk("t3 completions", n, 10);
    chk("t3 starve_cnt after dbg grant", 32'(u_dut.starve_cnt), 0);

    // T4: CPU completes, drops req; debug arriving mid-access is next
    tick();
    a.cpu_req_i = 1; a.cpu_we_i = 0; a.cpu_addr_i = 32'h14;
    a.dbg_we_i = 0; a.dbg_addr_i = 32'h18;
    sb0.push_back('{1'b0, 1'b1, 32'hA000_0005});
    sb0.push_back('{1'b1, 1'b1, 32'hA000_0006});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("t4 cpu_done c%0d", k), a.cpu_done_o, (k == 3));
      chk($sformatf("t4 dbg_done c%0d", k), a.dbg_done_o, (k == 7));
      tick();
      if (k == 0) a.dbg_req_i = 1;
      if (k == 3) a.cpu_req_i = 0;
      if (k == 7) a.dbg_req_i = 0;
    end

    // T5: reset during first BUSY cycle of a CPU write
    we_cnt = 0;
    a.cpu_req_i = 1; a.cpu_we_i = 1; a.cpu_addr_i = 32'h30; a.cpu_wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t5 mem_en in BUSY", a.mem_en_o, 1);
    rst = 1;
    #1;
    chk("t5 mem_en async drop", a.mem_en_o, 0);
    chk("t5 mem_we async drop", a.mem_we_o, 0);
    a.cpu_req_i = 0; a.cpu_we_i = 0;
    tick();
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("t5 no done c%0d", k), {a.cpu_done_o, a.dbg_done_o}, 0);
    end
    chk("t5 write count", we_cnt, 0);
    chk("t5 mem[0x30] kept", mem[12], 32'hA000_000C);
    tick();
    a.cpu_req_i = 1; a.cpu_addr_i = 32'h30;
    sb0.push_back('{1'b0, 1'b1, 32'hA000_000C});
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (a.cpu_done_o) begin
        seen = 1;
        chk("t5 read-after-reset done cycle", k, 3);
      end
      tick();
    end
    a.cpu_req_i = 0;
    chk("t5 read-after-reset completed", seen, 1);

    // T6: MEM_LAT=1 instance: read then write
    b.cpu_req_i = 1; b.cpu_we_i = 0; b.cpu_addr_i = 32'h8;
    sb1.push_back('{1'b0, 1'b1, 32'h1234_0008});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t6 cpu_done c%0d", k), b.cpu_done_o, (k == 2));
      chk($sformatf("t6 mem_en c%0d", k), b.mem_en_o, (k == 1));
      tick();
      if (k == 2) b.cpu_req_i = 0;
    end
    we1_cnt = 0;
    b.dbg_req_i = 1; b.dbg_we_i = 1; b.dbg_addr_i = 32'hC; b.dbg_wdata_i = 32'h77;
    sb1.push_back('{1'b1, 1'b0, 32'h0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t6 mem_we c%0d", k), b.mem_we_o, (k == 1));
      chk($sformatf("t6 dbg_done c%0d", k), b.dbg_done_o, (k == 2));
      tick();
      if (k == 2) b.dbg_req_i = 0;
    end
    chk("t6 write count", we1_cnt, 1);

    repeat (3) tick();
    chk("sb0 drained", sb0.size(), 0);
    chk("sb1 drained", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
